// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage: holds one instruction, waits for its in-order data_ok,
// buffers the response across writeback stalls, extracts load data and discards stale responses.
module mem_resp_stage #(
    parameter int DROP_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exe_to_mem_valid,
    output logic        mem_allowin,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_result,
    input  logic        in_res_from_mem,
    input  logic        in_req_sent,
    input  logic [1:0]  in_mem_size,
    input  logic        in_load_sign,
    input  logic        in_rf_we,
    input  logic [4:0]  in_rf_waddr,
    input  logic        in_excp,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        wb_allowin,
    input  logic        wb_flush,
    output logic        mem_to_wb_valid,
    output logic [31:0] out_pc,
    output logic        out_rf_we,
    output logic [4:0]  out_rf_waddr,
    output logic [31:0] out_rf_wdata,
    output logic        out_excp,
    output logic        mem_fwd_valid,
    output logic [4:0]  mem_fwd_waddr,
    output logic [31:0] mem_fwd_wdata,
    output logic        mem_fwd_stall
);

    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    logic              mem_valid_q;
    logic [31:0]       pc_q;
    logic [31:0]       result_q;
    logic              res_from_mem_q;
    logic              req_sent_q;
    logic [1:0]        mem_size_q;
    logic              load_sign_q;
    logic              rf_we_q;
    logic [4:0]        rf_waddr_q;
    logic              excp_q;
    logic              buf_valid_q;
    logic [31:0]       rdata_buf_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic [DROP_W-1:0] drop_cnt_d;

    logic        wait_w;
    logic        own_w;
    logic        ready_go;
    logic        advance;
    logic        load_fire;
    logic        buf_capture;
    logic        drop_inc_stage;
    logic        drop_inc_entry;
    logic        drop_dec;
    logic [DROP_W+1:0] drop_sum;
    logic [31:0] src_data;
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] load_data;

    assign wait_w          = mem_valid_q & req_sent_q & ~excp_q & ~buf_valid_q;
    assign own_w           = data_sram_data_ok & (drop_cnt_q == '0);
    assign ready_go        = ~wait_w | own_w;
    assign advance         = ready_go & wb_allowin;
    assign mem_allowin     = ~mem_valid_q | advance;
    assign load_fire       = mem_allowin & exe_to_mem_valid;
    assign buf_capture     = own_w & wait_w & ~wb_allowin;
    assign mem_to_wb_valid = mem_valid_q & ready_go & ~wb_flush;

    // Requests killed by a flush still answer on the in-order bus; count them so they are swallowed.
    assign drop_inc_stage = wb_flush & mem_valid_q & wait_w & ~own_w;
    assign drop_inc_entry = wb_flush & load_fire & in_req_sent;
    assign drop_dec       = data_sram_data_ok & (drop_cnt_q != '0);

    always_comb begin
        drop_sum = {2'b00, drop_cnt_q}
                 + {{(DROP_W+1){1'b0}}, drop_inc_stage}
                 + {{(DROP_W+1){1'b0}}, drop_inc_entry}
                 - {{(DROP_W+1){1'b0}}, drop_dec};
        drop_cnt_d = drop_cnt_q;
        if (drop_sum > {2'b00, DROP_MAX}) begin
            drop_cnt_d = DROP_MAX;
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
    end

    always_comb begin
        src_data  = buf_valid_q ? rdata_buf_q : data_sram_rdata;
        byte_sh   = src_data >> {result_q[1:0], 3'b000};
        half_sh   = src_data >> {result_q[1], 4'b0000};
        load_data = src_data;
        case (mem_size_q)
            2'b00:   load_data = {{24{load_sign_q & byte_sh[7]}}, byte_sh[7:0]};
            2'b01:   load_data = {{16{load_sign_q & half_sh[15]}}, half_sh[15:0]};
            default: load_data = src_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid_q <= 1'b0;
            buf_valid_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (wb_flush) begin
                mem_valid_q <= 1'b0;
            end else if (mem_allowin) begin
                mem_valid_q <= exe_to_mem_valid;
            end
            if (wb_flush | advance) begin
                buf_valid_q <= 1'b0;
            end else if (buf_capture) begin
                buf_valid_q <= 1'b1;
            end
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            pc_q           <= in_pc;
            result_q       <= in_result;
            res_from_mem_q <= in_res_from_mem;
            req_sent_q     <= in_req_sent;
            mem_size_q     <= in_mem_size;
            load_sign_q    <= in_load_sign;
            rf_we_q        <= in_rf_we;
            rf_waddr_q     <= in_rf_waddr;
            excp_q         <= in_excp;
        end
        if (buf_capture) begin
            rdata_buf_q <= data_sram_rdata;
        end
    end

    assign out_pc        = pc_q;
    assign out_rf_we     = rf_we_q & ~excp_q;
    assign out_rf_waddr  = rf_waddr_q;
    assign out_rf_wdata  = res_from_mem_q ? load_data : result_q;
    assign out_excp      = excp_q;
    assign mem_fwd_valid = mem_valid_q & out_rf_we & (rf_waddr_q != 5'd0);
    assign mem_fwd_waddr = rf_waddr_q;
    assign mem_fwd_wdata = out_rf_wdata;
    assign mem_fwd_stall = mem_valid_q & res_from_mem_q & rf_we_q & ~ready_go;

endmodule
